// File: rtl/vga_text_pkg.sv
// Shared timing defaults, glyph geometry, control codes and FSM state for the VGA text console.
// The CURSOR_BLINK_EN build option lives in vga_text_console; BLINK_FRAMES is its half-period.
package vga_text_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;
  localparam int XB_W   = $clog2(CHAR_W);
  localparam int GR_W   = $clog2(CHAR_H);

  localparam int BLINK_FRAMES = 30;

  localparam logic [7:0] CHR_SPACE = 8'h20;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_BS    = 8'h08;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  typedef struct packed {
    logic            active;
    logic            h_sync;
    logic            v_sync;
    logic [XB_W-1:0] xbit;
    logic [GR_W-1:0] grow;
  } pix_s1_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running pixel/line counters with raw (unaligned) syncs and active-area flag.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int XW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int YW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          h_sync,
  output logic          v_sync,
  output logic          active
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (x == XW'(H_TOTAL - 1)) begin
      x <= '0;
      if (y == YW'(V_TOTAL - 1))
        y <= '0;
      else
        y <= y + YW'(1);
    end else begin
      x <= x + XW'(1);
    end
  end

  always_comb begin
    h_sync = !((32'(x) >= HS_BEG) && (32'(x) < HS_END));
    v_sync = !((32'(y) >= VS_BEG) && (32'(y) < VS_END));
    active = (32'(x) < H_ACTIVE) && (32'(y) < V_ACTIVE);
  end

endmodule

// File: rtl/vga_text_console.sv
// VGA text console: char buffer, cursor write FSM and 2-stage font pixel pipeline.
// Define CURSOR_BLINK_EN to draw a blinking underline cursor.
module vga_text_console
  import vga_text_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_char,
  input  logic       clr_req,
  output logic [7:0] font_char,
  output logic [3:0] font_row,
  input  logic [7:0] font_bits,
  output logic       vga_h_sync,
  output logic       vga_v_sync,
  output logic       in_display,
  output logic       pixel_on,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int COLS    = H_ACTIVE / CHAR_W;
  localparam int ROWS    = V_ACTIVE / CHAR_H;
  localparam int CELLS   = COLS * ROWS;
  localparam int ADDR_W  = $clog2(CELLS);
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          h_raw;
  logic          v_raw;
  logic          act_raw;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .XW       (XW),
    .YW       (YW)
  ) u_timing (
    .clk    (clk),
    .rst_n  (rst_n),
    .x      (x),
    .y      (y),
    .h_sync (h_raw),
    .v_sync (v_raw),
    .active (act_raw)
  );

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] cur_addr;
  logic              accept;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;

  logic [6:0]        cell_col;
  logic [4:0]        cell_row;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_char;
  logic [7:0]        char_mem [CELLS];

  pix_s1_t s1;
  logic    glyph_bit;

  assign accept   = wr_valid & wr_ready;
  assign cur_addr = ADDR_W'(32'(cursor_row) * COLS
                            + 32'(cursor_col));

  always_comb begin
    we    = 1'b0;
    waddr = clr_addr;
    wdata = CHR_SPACE;
    unique case (state)
      ST_CLEAR: we = 1'b1;
      ST_IDLE: begin
        if (accept && !clr_req) begin
          unique case (1'b1)
            (wr_char == CHR_LF): we = 1'b0;
            (wr_char == CHR_BS): begin
              we    = (cursor_col != 7'd0);
              waddr = cur_addr - ADDR_W'(1);
            end
            default: begin
              we    = 1'b1;
              waddr = cur_addr;
              wdata = wr_char;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_CLEAR;
      clr_addr   <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      wr_ready   <= 1'b0;
    end else begin
      unique case (state)
        ST_CLEAR: begin
          cursor_col <= '0;
          cursor_row <= '0;
          if (clr_addr == ADDR_W'(CELLS - 1)) begin
            state    <= ST_IDLE;
            clr_addr <= '0;
            wr_ready <= 1'b1;
          end else begin
            clr_addr <= clr_addr + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          if (clr_req) begin
            state      <= ST_CLEAR;
            clr_addr   <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
            wr_ready   <= 1'b0;
          end else if (accept) begin
            unique case (1'b1)
              (wr_char == CHR_LF): begin
                cursor_col <= '0;
                cursor_row <= (cursor_row == 5'(ROWS - 1))
                              ? '0 : cursor_row + 5'd1;
              end
              (wr_char == CHR_BS): begin
                if (cursor_col != 7'd0)
                  cursor_col <= cursor_col - 7'd1;
              end
              default: begin
                if (cursor_col == 7'(COLS - 1)) begin
                  cursor_col <= '0;
                  cursor_row <= (cursor_row == 5'(ROWS - 1))
                                ? '0 : cursor_row + 5'd1;
                end else begin
                  cursor_col <= cursor_col + 7'd1;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  // Write and display ports are independent; no arbitration needed.
  always_ff @(posedge clk) begin
    if (we)
      char_mem[waddr] <= wdata;
    rd_char <= char_mem[rd_addr];
  end

  always_comb begin
    cell_col = 7'(32'(x) / CHAR_W);
    cell_row = 5'(32'(y) / CHAR_H);
    rd_addr  = act_raw
             ? ADDR_W'(32'(cell_row) * COLS + 32'(cell_col))
             : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '{active: 1'b0, h_sync: 1'b1, v_sync: 1'b1,
              xbit: '0, grow: '0};
    end else begin
      s1 <= '{active: act_raw,
              h_sync: h_raw,
              v_sync: v_raw,
              xbit:   XB_W'(32'(x) % CHAR_W),
              grow:   GR_W'(32'(y) % CHAR_H)};
    end
  end

  assign font_char = rd_char;
  assign font_row  = s1.grow;

`ifdef CURSOR_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES);

  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic          under_s1;
  logic          frame_end;
  logic          cur_cell;

  assign frame_end = (x == XW'(H_TOTAL - 1))
                   && (y == YW'(V_TOTAL - 1));
  assign cur_cell  = (cell_col == cursor_col)
                   && (cell_row == cursor_row)
                   && (32'(y) % CHAR_H >= CHAR_H - 2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
      under_s1  <= 1'b0;
    end else begin
      under_s1 <= phase & act_raw & cur_cell;
      if (frame_end) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  assign glyph_bit =
    font_bits[XB_W'(CHAR_W - 1) - s1.xbit] | under_s1;
`else
  assign glyph_bit = font_bits[XB_W'(CHAR_W - 1) - s1.xbit];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_h_sync <= 1'b1;
      vga_v_sync <= 1'b1;
      in_display <= 1'b0;
      pixel_on   <= 1'b0;
    end else begin
      vga_h_sync <= s1.h_sync;
      vga_v_sync <= s1.v_sync;
      in_display <= s1.active;
      pixel_on   <= s1.active & glyph_bit;
    end
  end

endmodule

// File: tb/tb_vga_text_console.sv
// Self-checking bench for vga_text_console with a shortened vertical frame.
module tb_vga_text_console;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 32, VF = 2, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int COLS  = HA / 8;
  localparam int ROWS  = VA / 16;
  localparam int CELLS = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_char = 8'h00;
  logic       clr_req = 1'b0;
  logic [7:0] font_char;
  logic [3:0] font_row;
  logic [7:0] font_bits;
  logic       vga_h_sync, vga_v_sync, in_display, pixel_on;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] mem_m [CELLS];
  int m_col = 0;
  int m_row = 0;

  always #5 clk = ~clk;

  vga_text_console #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_char    (wr_char),
    .clr_req    (clr_req),
    .font_char  (font_char),
    .font_row   (font_row),
    .font_bits  (font_bits),
    .vga_h_sync (vga_h_sync),
    .vga_v_sync (vga_v_sync),
    .in_display (in_display),
    .pixel_on   (pixel_on),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  function automatic logic [7:0] font_fn(input logic [7:0] ch,
                                         input logic [3:0] r);
    if (ch == 8'h20) return 8'h00;
    if (ch == 8'h41) return 8'h81;
    return ch ^ (8'(r) * 8'h1D);
  endfunction

  assign font_bits = font_fn(font_char, font_row);

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) mem_m[i] = 8'h20;
    m_col = 0;
    m_row = 0;
  endtask

  task automatic model_put(input logic [7:0] c);
    if (c == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
    end else if (c == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        mem_m[m_row * COLS + m_col] = 8'h20;
      end
    end else begin
      mem_m[m_row * COLS + m_col] = c;
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
      end
    end
  endtask

  task automatic put(input logic [7:0] c);
    int n = 0;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_char  = c;
    while (!wr_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_assert++;
      n_fail++;
      $error("FAIL wr_timeout: wr_ready stayed 0, expected 1");
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    model_put(c);
  endtask

  task automatic check_cursor(input string tag);
    @(negedge clk);
    check({tag, "_col"}, 32'(cursor_col), 32'(m_col));
    check({tag, "_row"}, 32'(cursor_row), 32'(m_row));
  endtask

  // Counts clocks until wr_ready rises; optional clr pulse mid-way.
  task automatic measure_clear(input string tag, input int pulse_at);
    int n = 0;
    while (!wr_ready && n < 10000) begin
      clr_req = (n == pulse_at);
      @(posedge clk);
      #1;
      n++;
    end
    clr_req = 1'b0;
    check(tag, n, CELLS);
  endtask

  task automatic scan_frame(input bit with_a);
    int he = 0, ve = 0, de = 0, pe = 0;
    int fall_px = -1, run = 0, first_run = -1;
    int vs_fall_py = -1, vs_low = 0, hs_low = 0;
    int a_edge = 0, a_mid = 0;
    int p, px, py;
    logic prev_hs = 1'b1, prev_vs = 1'b1;
    logic e_hs, e_vs, e_disp, e_pix;
    logic [7:0] bits;
    repeat (3) @(posedge clk);
    for (int k = 0; k < HT * VT; k++) begin
      @(posedge clk);
      #1;
      p  = cyc - 2;
      px = p % HT;
      py = (p / HT) % VT;
      e_hs   = !(px >= HA + HF && px < HA + HF + HS);
      e_vs   = !(py >= VA + VF && py < VA + VF + VS);
      e_disp = (px < HA) && (py < VA);
      e_pix  = 1'b0;
      if (e_disp) begin
        bits  = font_fn(mem_m[(py / 16) * COLS + px / 8], 4'(py % 16));
        e_pix = bits[7 - px % 8];
      end
      if (vga_h_sync !== e_hs) he++;
      if (vga_v_sync !== e_vs) ve++;
      if (in_display !== e_disp) de++;
      if (pixel_on !== e_pix) pe++;
      if (k > 0 && prev_hs && !vga_h_sync && fall_px < 0) begin
        fall_px = px;
        run = 0;
      end
      if (!vga_h_sync && fall_px >= 0 && first_run < 0) run++;
      if (k > 0 && !prev_hs && vga_h_sync && fall_px >= 0
          && first_run < 0) first_run = run;
      if (k > 0 && prev_vs && !vga_v_sync && vs_fall_py < 0)
        vs_fall_py = py;
      if (!vga_h_sync) hs_low++;
      if (!vga_v_sync) vs_low++;
      prev_hs = vga_h_sync;
      prev_vs = vga_v_sync;
      if (py < 16 && px < 8 && pixel_on) begin
        if (px == 0 || px == 7) a_edge++;
        else a_mid++;
      end
    end
    check("scan_hsync_errs", he, 0);
    check("scan_vsync_errs", ve, 0);
    check("scan_display_errs", de, 0);
    check("scan_pixel_errs", pe, 0);
    check("hsync_fall_x", fall_px, HA + HF);
    check("hsync_low_len", first_run, HS);
    check("vsync_fall_line", vs_fall_py, VA + VF);
    check("vsync_low_clks", vs_low, VS * HT);
    check("hsync_low_clks", hs_low, HS * VT);
    if (with_a) begin
      check("a_cell_edge_px", a_edge, 32);
      check("a_cell_mid_px", a_mid, 0);
    end
  endtask

  initial begin
    model_clear();
    repeat (4) @(posedge clk);
    #1;
    check("rst_wr_ready", 32'(wr_ready), 0);
    check("rst_hsync", 32'(vga_h_sync), 1);
    check("rst_vsync", 32'(vga_v_sync), 1);
    check("rst_in_display", 32'(in_display), 0);
    check("rst_pixel_on", 32'(pixel_on), 0);
    check("rst_cursor_col", 32'(cursor_col), 0);
    check("rst_cursor_row", 32'(cursor_row), 0);

    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("mid_clear_ready", 32'(wr_ready), 0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    measure_clear("reset_clear_clks", -1);
    check_cursor("post_reset");

    put(8'h08);
    check_cursor("bs_at_col0");
    put(8'h41);
    for (int i = 0; i < 80; i++) put(8'($urandom_range(33, 126)));
    check_cursor("after_81");

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 9) < 2) put(8'h08);
      else put(8'($urandom_range(32, 126)));
    end
    check_cursor("random_mix");

    while (m_row != ROWS - 1) put(8'h0A);
    check_cursor("lf_last_row");
    put(8'h0A);
    check_cursor("lf_wrap");

    scan_frame(1'b1);

    for (int i = 0; i < 3; i++) put(8'($urandom_range(33, 126)));
    check_cursor("pre_clear");

    @(negedge clk);
    clr_req  = 1'b1;
    wr_valid = 1'b1;
    wr_char  = 8'h5A;
    @(posedge clk);
    #1;
    clr_req  = 1'b0;
    wr_valid = 1'b0;
    check("clr_ready_drop", 32'(wr_ready), 0);
    model_clear();
    measure_clear("clr_clear_clks", 100);
    check_cursor("post_clear");

    scan_frame(1'b0);

    put(8'h42);
    check_cursor("write_after_clear");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
